// File: rtl/jk_pkg.sv
// Shared types and constants for the JK sequence driver: FSM states,
// {J,K} excitation codes and default sizes.
package jk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_t;

  // Excitation codes are packed as {J,K}
  localparam logic [1:0] HOLD = 2'b00;
  localparam logic [1:0] CLR  = 2'b01;
  localparam logic [1:0] SETB = 2'b10;
  localparam logic [1:0] TOG  = 2'b11;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/jk_seq_driver_if.sv
// Target handshake bundle: valid/ready, requested bank state and excitation mode.
interface jk_seq_driver_if
  import jk_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic             tgt_valid;
  logic             tgt_ready;
  logic [WIDTH-1:0] tgt_data;
  logic             mode;

  modport master (output tgt_valid, output tgt_data, output mode, input tgt_ready);
  modport slave  (input tgt_valid, input tgt_data, input mode, output tgt_ready);

endinterface

// File: rtl/jkff_cell.sv
// Single JK flip-flop with asynchronous clear and synchronous preset.
module jkff_cell
  import jk_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic set,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qbar
);

  // Reset beats preset, preset beats the J/K excitation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= 1'b0;
    end else if (set) begin
      q <= 1'b1;
    end else begin
      case ({j, k})
        CLR:     q <= 1'b0;
        SETB:    q <= 1'b1;
        TOG:     q <= ~q;
        default: q <= q;
      endcase
    end
  end

  assign qbar = ~q;

endmodule

// File: rtl/jk_seq_driver.sv
// Accepts a target bank state, excites a bank of JK cells toward it for one
// cycle, then reports completion, mismatch and a saturating transition count.
module jk_seq_driver
  import jk_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  jk_seq_driver_if.slave   tgt,
  input  logic             set,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic             done,
  output logic             mismatch,
  output logic [CNT_W-1:0] trans_cnt
);

  localparam int PW = $clog2(WIDTH + 1);
  localparam int SW = ((CNT_W > PW) ? CNT_W : PW) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] tgt_reg;
  logic             mode_reg;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] qbar;
  logic [PW-1:0]    pop;
  logic [SW-1:0]    sum;
  logic             accept;
  logic             drive;

  assign accept = tgt.tgt_valid && (state_reg == IDLE);
  assign drive  = (state_reg == DRIVE);
  assign diff   = q ^ tgt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      tgt_reg   <= '0;
      mode_reg  <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        tgt_reg  <= tgt.tgt_data;
        mode_reg <= tgt.mode;
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    tgt.tgt_ready = 1'b0;
    done          = 1'b0;
    mismatch      = 1'b0;
    case (state_reg)
      IDLE: begin
        tgt.tgt_ready = 1'b1;
        if (tgt.tgt_valid) state_next = DRIVE;
      end
      DRIVE: state_next = CHECK;
      CHECK: begin
        done       = 1'b1;
        mismatch   = (q != tgt_reg);
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Bits that flip on the DRIVE->CHECK edge, measured before the bank moves
  always_comb begin
    pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop = pop + PW'(diff[i]);
    end
    sum      = SW'(cnt_reg) + SW'(pop);
    cnt_next = cnt_reg;
    if (drive) begin
      cnt_next = (sum > SW'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];
    end
  end

  assign trans_cnt = cnt_reg;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bank
      // Mode 1 toggles differing bits; mode 0 sets or clears them explicitly
      assign j[gi] = drive && (mode_reg ? diff[gi] : (~q[gi] &  tgt_reg[gi]));
      assign k[gi] = drive && (mode_reg ? diff[gi] : ( q[gi] & ~tgt_reg[gi]));

      jkff_cell u_cell (
        .clk  (clk),
        .rst  (rst),
        .set  (set),
        .j    (j[gi]),
        .k    (k[gi]),
        .q    (q[gi]),
        .qbar (qbar[gi])
      );
    end
  endgenerate

endmodule

// File: doc/jk_seq_driver.md
JK_SEQ_DRIVER -- requirements
Module: jk_seq_driver

Interface
REQ-001 SHALL have parameter WIDTH, default 4, number of JK bit cells driven.
REQ-002 SHALL have parameter CNT_W, default 8, width of the transition counter.
REQ-003 SHALL have one clock and an asynchronous, active-high reset.
REQ-004 CLK  input  1  single clock, all state on rising edge.
REQ-005 RST  input  1  asynchronous, active-high reset.
REQ-006 TGT_VALID  input  1  target state offered.
REQ-007 TGT_READY  output  1  block can accept a target.
REQ-008 TGT_DATA  input  WIDTH  requested next state of the JK bank.
REQ-009 MODE  input  1  0 = hold/set/reset excitation, 1 = toggle excitation; sampled on accept.
REQ-010 SET  input  1  synchronous preset of the whole bank to all-ones; overrides J/K.
REQ-011 J  output  WIDTH  J excitation presented to the bank.
REQ-012 K  output  WIDTH  K excitation presented to the bank.
REQ-013 Q  output  WIDTH  current bank state.
REQ-014 DONE  output  1  one-cycle pulse, target transfer complete.
REQ-015 MISMATCH  output  1  valid with DONE: Q differs from accepted target.
REQ-016 TRANS_CNT  output  CNT_W  saturating count of bit transitions made.

Function
REQ-017 SHALL implement FSM IDLE -> DRIVE -> CHECK -> IDLE.
REQ-018 TGT_READY SHALL be 1 only in IDLE; accept occurs on the edge where TGT_VALID and TGT_READY are both 1.
REQ-019 On accept, the block SHALL register TGT_DATA and MODE and enter DRIVE; TGT_VALID without READY is ignored.
REQ-020 In DRIVE with MODE=0, per bit: Q 0->0 gives J=0,K=0; 0->1 gives J=1,K=0; 1->0 gives J=0,K=1; 1->1 gives J=0,K=0.
REQ-021 In DRIVE with MODE=1, per bit: J=K=1 where Q differs from the target, J=K=0 otherwise.
REQ-022 J and K SHALL be all-zero in IDLE and CHECK.
REQ-023 Each bank bit SHALL follow JK semantics: 00 hold, 01 clear, 10 set, 11 toggle.
REQ-024 The bank SHALL update on the DRIVE->CHECK edge; latency from accept to DONE SHALL be 2 cycles; throughput SHALL be one target per 3 cycles.
REQ-025 In CHECK, DONE SHALL be 1 for exactly one cycle; MISMATCH SHALL be 1 iff Q != registered target, and 0 outside CHECK.
REQ-026 On the DRIVE->CHECK edge, TRANS_CNT SHALL add popcount(Q XOR target) computed before the update, saturating at 2^CNT_W-1, with no wrap.
REQ-027 SET=1 on any edge SHALL force Q to all-ones regardless of J/K and FSM state; FSM and counter are unaffected.
REQ-028 SET=1 on the DRIVE->CHECK edge SHALL still allow REQ-026 counting and SHALL flag MISMATCH unless the target is all-ones.

Reset
REQ-029 RST=1 SHALL immediately force FSM=IDLE, Q=0, J=0, K=0, DONE=0, MISMATCH=0, TRANS_CNT=0, and TGT_READY=1, independent of CLK.
REQ-030 Reset asserted mid-DRIVE or mid-CHECK SHALL abort the transfer with no DONE pulse; operation resumes on the first edge after release.
REQ-031 RST SHALL take priority over SET.

Structure
REQ-032 Shared package jk_pkg SHALL hold the FSM state typedef, the JK excitation encodings (HOLD, CLR, SETB, TOG) and the default WIDTH and CNT_W constants.
REQ-033 Each bank bit SHALL be one instance of sub-module jkff_cell (CLK, RST, SET, J, K, Q, QBAR).

Verification
REQ-034 Reset, then WIDTH=4, MODE=0, target 4'b1010 -> DRIVE cycle J=1010, K=0000; DONE after 2 cycles; Q=1010; MISMATCH=0; TRANS_CNT=2.
REQ-035 Next, MODE=1, target 4'b0101 -> J=K=1111; Q=0101; MISMATCH=0; TRANS_CNT=6.
REQ-036 SET=1 on the DRIVE->CHECK edge with target 4'b0011 -> Q=1111; DONE=1; MISMATCH=1.
REQ-037 TGT_VALID held high continuously -> TGT_READY pattern 1,0,0 repeats; one DONE per 3 cycles.
REQ-038 CNT_W=3 with a stream of 4'b1111/4'b0000 targets -> TRANS_CNT saturates at 7 and stays there.
REQ-039 RST pulsed asynchronously mid-DRIVE -> Q=0 and TRANS_CNT=0 at once; no DONE; a new accept is taken on the first edge after release.
